// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand stage (ID/EX boundary).
package alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = 32;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] ALU_AND  = 4'b0010;
   localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'b0101;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'b0110;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'b0111;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'b1000;
   localparam logic [OP_W-1:0] ALU_NOP  = 4'b1001;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'b1010;
   localparam logic [OP_W-1:0] ALU_LUI  = 4'b1110;

   typedef enum logic [1:0] {
      FWD_REG,
      FWD_MEM,
      FWD_WB
   } fwd_sel_t;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              src_a_pc;
      logic              src_b_imm;
      logic [OP_W-1:0]   operation;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [DATA_W-1:0] rs1_data;
      logic [DATA_W-1:0] rs2_data;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
   } idex_t;

   // Empty EX slot: no control effects, ALU computes a zero result.
   function automatic idex_t idex_bubble();
      idex_t b;
      b           = '0;
      b.operation = ALU_NOP;
      return b;
   endfunction

endpackage

// File: rtl/forward_unit.sv
// Selects the source of each EX-stage register operand: MEM beats WB beats the register file.
module forward_unit
   import alu_pkg::*;
#(
   parameter int unsigned REG_ADDR = REG_W
) (
   input  logic [REG_ADDR-1:0] i_rs1,
   input  logic [REG_ADDR-1:0] i_rs2,
   input  logic [REG_ADDR-1:0] i_mem_rd,
   input  logic                i_mem_reg_write,
   input  logic [REG_ADDR-1:0] i_wb_rd,
   input  logic                i_wb_reg_write,
   output fwd_sel_t            o_fwd_a,
   output fwd_sel_t            o_fwd_b
);

   logic w_mem_live;
   logic w_wb_live;

   // x0 is hard-wired zero, so a write to it is never a forwarding source.
   assign w_mem_live = i_mem_reg_write && (i_mem_rd != '0);
   assign w_wb_live  = i_wb_reg_write  && (i_wb_rd  != '0);

   always_comb begin
      o_fwd_a = FWD_REG;
      o_fwd_b = FWD_REG;
      if (w_mem_live && (i_mem_rd == i_rs1)) begin
         o_fwd_a = FWD_MEM;
      end else if (w_wb_live && (i_wb_rd == i_rs1)) begin
         o_fwd_a = FWD_WB;
      end
      if (w_mem_live && (i_mem_rd == i_rs2)) begin
         o_fwd_b = FWD_MEM;
      end else if (w_wb_live && (i_wb_rd == i_rs2)) begin
         o_fwd_b = FWD_WB;
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion,
// feeding SrcA/SrcB/Operation directly into the ALU.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DATA_W,
   parameter int unsigned OPCODE_LENGTH = OP_W,
   parameter int unsigned REG_ADDR      = REG_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    id_rs1_data,
   input  logic [DATA_WIDTH-1:0]    id_rs2_data,
   input  logic [DATA_WIDTH-1:0]    id_imm,
   input  logic [DATA_WIDTH-1:0]    id_pc,
   input  logic [REG_ADDR-1:0]      id_rs1,
   input  logic [REG_ADDR-1:0]      id_rs2,
   input  logic [REG_ADDR-1:0]      id_rd,
   input  logic                     id_use_rs1,
   input  logic                     id_use_rs2,
   input  logic                     id_src_a_pc,
   input  logic                     id_src_b_imm,
   input  logic [OPCODE_LENGTH-1:0] id_operation,
   input  logic                     id_reg_write,
   input  logic                     id_mem_read,
   input  logic                     id_mem_write,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [REG_ADDR-1:0]      mem_rd,
   input  logic                     mem_reg_write,
   input  logic [DATA_WIDTH-1:0]    mem_result,
   input  logic [REG_ADDR-1:0]      wb_rd,
   input  logic                     wb_reg_write,
   input  logic [DATA_WIDTH-1:0]    wb_result,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     ex_valid,
   output logic                     ex_reg_write,
   output logic                     ex_mem_read,
   output logic                     ex_mem_write,
   output logic [REG_ADDR-1:0]      ex_rd,
   output logic [DATA_WIDTH-1:0]    ex_store_data,
   output logic                     load_use_hazard,
   output logic [31:0]              bubble_count
);

   idex_t                  r_ex;
   idex_t                  w_ex_next;
   idex_t                  w_capture;
   logic [CNT_W-1:0]       r_bubble_count;
   logic                   w_load_use;
   logic                   w_count_bubble;
   fwd_sel_t               w_fwd_a;
   fwd_sel_t               w_fwd_b;
   logic [DATA_WIDTH-1:0]  w_rs1_fwd;
   logic [DATA_WIDTH-1:0]  w_rs2_fwd;

   // A load in EX cannot supply its value until MEM, so a dependent decode must wait one cycle.
   assign w_load_use = in_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) &&
                       ((id_use_rs1 && (REG_W'(id_rs1) == r_ex.rd)) ||
                        (id_use_rs2 && (REG_W'(id_rs2) == r_ex.rd)));

   assign load_use_hazard = w_load_use;
   assign in_ready        = !stall && !w_load_use;

   always_comb begin
      w_capture           = '0;
      w_capture.valid     = 1'b1;
      w_capture.reg_write = id_reg_write;
      w_capture.mem_read  = id_mem_read;
      w_capture.mem_write = id_mem_write;
      w_capture.src_a_pc  = id_src_a_pc;
      w_capture.src_b_imm = id_src_b_imm;
      w_capture.operation = OP_W'(id_operation);
      w_capture.rd        = REG_W'(id_rd);
      w_capture.rs1       = REG_W'(id_rs1);
      w_capture.rs2       = REG_W'(id_rs2);
      w_capture.rs1_data  = DATA_W'(id_rs1_data);
      w_capture.rs2_data  = DATA_W'(id_rs2_data);
      w_capture.imm       = DATA_W'(id_imm);
      w_capture.pc        = DATA_W'(id_pc);
   end

   // Update priority: flush, then stall, then load-use bubble, then capture.
   always_comb begin
      w_ex_next      = r_ex;
      w_count_bubble = 1'b0;
      if (flush) begin
         w_ex_next = idex_bubble();
      end else if (stall) begin
         w_ex_next = r_ex;
      end else if (w_load_use) begin
         w_ex_next      = idex_bubble();
         w_count_bubble = 1'b1;
      end else if (in_valid) begin
         w_ex_next = w_capture;
      end else begin
         w_ex_next = idex_bubble();
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex           <= idex_bubble();
         r_bubble_count <= '0;
      end else begin
         r_ex <= w_ex_next;
         if (w_count_bubble && (r_bubble_count != '1)) begin
            r_bubble_count <= r_bubble_count + CNT_W'(1);
         end
      end
   end

   forward_unit #(
      .REG_ADDR        (REG_W)
   ) u_forward_unit (
      .i_rs1           (r_ex.rs1),
      .i_rs2           (r_ex.rs2),
      .i_mem_rd        (REG_W'(mem_rd)),
      .i_mem_reg_write (mem_reg_write),
      .i_wb_rd         (REG_W'(wb_rd)),
      .i_wb_reg_write  (wb_reg_write),
      .o_fwd_a         (w_fwd_a),
      .o_fwd_b         (w_fwd_b)
   );

   always_comb begin
      w_rs1_fwd = DATA_WIDTH'(r_ex.rs1_data);
      w_rs2_fwd = DATA_WIDTH'(r_ex.rs2_data);
      case (w_fwd_a)
         FWD_MEM: w_rs1_fwd = mem_result;
         FWD_WB:  w_rs1_fwd = wb_result;
         default: w_rs1_fwd = DATA_WIDTH'(r_ex.rs1_data);
      endcase
      case (w_fwd_b)
         FWD_MEM: w_rs2_fwd = mem_result;
         FWD_WB:  w_rs2_fwd = wb_result;
         default: w_rs2_fwd = DATA_WIDTH'(r_ex.rs2_data);
      endcase
   end

   assign SrcA          = r_ex.src_a_pc  ? DATA_WIDTH'(r_ex.pc)  : w_rs1_fwd;
   assign SrcB          = r_ex.src_b_imm ? DATA_WIDTH'(r_ex.imm) : w_rs2_fwd;
   assign ex_store_data = w_rs2_fwd;
   assign Operation     = OPCODE_LENGTH'(r_ex.operation);
   assign ex_valid      = r_ex.valid;
   assign ex_reg_write  = r_ex.reg_write;
   assign ex_mem_read   = r_ex.mem_read;
   assign ex_mem_write  = r_ex.mem_write;
   assign ex_rd         = REG_ADDR'(r_ex.rd);
   assign bubble_count  = 32'(r_bubble_count);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios plus random traffic against a behavioural model.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_src_a_pc, id_src_b_imm;
   logic [3:0]  id_operation;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic        stall, flush;
   logic [4:0]  mem_rd, wb_rd;
   logic        mem_reg_write, wb_reg_write;
   logic [31:0] mem_result, wb_result;
   logic [31:0] SrcA, SrcB, ex_store_data, bubble_count;
   logic [3:0]  Operation;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
   logic [4:0]  ex_rd;

   alu_operand_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm), .id_operation(id_operation),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .stall(stall), .flush(flush),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
      .load_use_hazard(load_use_hazard), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        v, rw, mr, mw, apc, bimm;
      bit [3:0]  op;
      bit [4:0]  rd, rs1, rs2;
      bit [31:0] d1, d2, imm, pc;
   } ex_t;

   typedef struct {
      bit [31:0] a, b, st, bc;
      bit [3:0]  op;
      bit        v, rw, mr, mw, lu, rdy;
      bit [4:0]  rd;
   } exp_t;

   ex_t       m_ex;
   bit [31:0] m_bc;
   exp_t      sb_q[$];
   int        n_checks = 0;
   int        n_err    = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic ex_t bubble();
      ex_t b;
      b    = '{default: 0};
      b.op = 4'b1001;
      return b;
   endfunction

   // Operand value seen in EX: youngest producer (MEM) first, then WB, else the captured value.
   function automatic bit [31:0] fwd(bit [4:0] idx, bit [31:0] regval);
      if (mem_reg_write && mem_rd != 0 && mem_rd == idx) return mem_result;
      if (wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_result;
      return regval;
   endfunction

   // Predict this cycle's outputs from current inputs, queue them, then advance the model one clock.
   task automatic eval();
      exp_t e;
      ex_t  nx;
      bit   lu;
      lu = in_valid && m_ex.v && m_ex.mr && (m_ex.rd != 0) &&
           ((id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd));
      e.a   = m_ex.apc  ? m_ex.pc  : fwd(m_ex.rs1, m_ex.d1);
      e.b   = m_ex.bimm ? m_ex.imm : fwd(m_ex.rs2, m_ex.d2);
      e.st  = fwd(m_ex.rs2, m_ex.d2);
      e.op  = m_ex.op;
      e.v   = m_ex.v;  e.rw = m_ex.rw; e.mr = m_ex.mr; e.mw = m_ex.mw; e.rd = m_ex.rd;
      e.lu  = lu;
      e.rdy = !stall && !lu;
      e.bc  = m_bc;
      sb_q.push_back(e);
      nx = m_ex;
      if (reset) begin
         nx   = bubble();
         m_bc = 0;
      end else if (flush) begin
         nx = bubble();
      end else if (stall) begin
         nx = m_ex;
      end else if (lu) begin
         nx = bubble();
         if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      end else if (in_valid) begin
         nx.v = 1; nx.rw = id_reg_write; nx.mr = id_mem_read; nx.mw = id_mem_write;
         nx.apc = id_src_a_pc; nx.bimm = id_src_b_imm; nx.op = id_operation;
         nx.rd = id_rd; nx.rs1 = id_rs1; nx.rs2 = id_rs2;
         nx.d1 = id_rs1_data; nx.d2 = id_rs2_data; nx.imm = id_imm; nx.pc = id_pc;
      end else begin
         nx = bubble();
      end
      m_ex = nx;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic cycle();
      eval();
      step();
   endtask

   task automatic peek();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_src_a_pc = 0; id_src_b_imm = 0; id_operation = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      stall = 0; flush = 0;
      mem_rd = 0; mem_reg_write = 0; mem_result = 0;
      wb_rd = 0; wb_reg_write = 0; wb_result = 0;
   endtask

   // Monitor: every cycle the DUT presents a full output set, checked against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_srca", SrcA, e.a);
            chk("sb_srcb", SrcB, e.b);
            chk("sb_store", ex_store_data, e.st);
            chk("sb_op", 32'(Operation), 32'(e.op));
            chk("sb_ctrl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, 1'b0},
                {27'd0, e.v, e.rw, e.mr, e.mw, 1'b0});
            chk("sb_rd", 32'(ex_rd), 32'(e.rd));
            chk("sb_hazard", {30'd0, load_use_hazard, in_ready}, {30'd0, e.lu, e.rdy});
            chk("sb_bubbles", bubble_count, e.bc);
         end
      end
   end

   initial begin
      reset = 1;
      idle();
      m_ex = bubble();
      m_bc = 0;
      step();

      // Reset state
      eval(); peek();
      chk("rst_valid", 32'(ex_valid), 0);
      chk("rst_op", 32'(Operation), 32'h9);
      chk("rst_ready", 32'(in_ready), 1);
      step();
      reset = 0;

      // Reset while an instruction sits in EX
      in_valid = 1; id_operation = 4'b0000; id_rs1 = 1; id_rs1_data = 32'h1111; id_rd = 2; id_reg_write = 1;
      cycle();
      in_valid = 0;
      reset = 1;
      #1;
      chk("rst_async_valid", 32'(ex_valid), 0);
      chk("rst_async_op", 32'(Operation), 32'h9);
      m_ex = bubble(); m_bc = 0;
      eval(); step();
      reset = 0;

      // Forwarding priority
      idle();
      in_valid = 1; id_operation = 4'b0000; id_rs1 = 5; id_rs2 = 6; id_rs1_data = 32'h99;
      id_use_rs1 = 1; id_rd = 7; id_reg_write = 1;
      cycle();
      in_valid = 0; stall = 1;
      mem_rd = 5; mem_reg_write = 1; mem_result = 32'h10;
      wb_rd = 5; wb_reg_write = 1; wb_result = 32'h20;
      eval(); peek(); chk("fwd_mem_prio", SrcA, 32'h10); step();
      mem_reg_write = 0;
      eval(); peek(); chk("fwd_wb", SrcA, 32'h20); step();
      stall = 0; in_valid = 1; id_rs1 = 0; id_rs1_data = 32'h77;
      mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1;
      cycle();
      in_valid = 0; stall = 1;
      eval(); peek(); chk("fwd_x0", SrcA, 32'h77); step();

      // Load-use: one bubble, then capture with MEM forwarding
      idle();
      in_valid = 1; id_operation = 4'b0000; id_rs1 = 2; id_use_rs1 = 1; id_rd = 3;
      id_mem_read = 1; id_reg_write = 1;
      cycle();
      id_mem_read = 0; id_rd = 4; id_rs1 = 1; id_rs2 = 3; id_use_rs2 = 1; id_rs2_data = 32'h555;
      eval(); peek();
      chk("lu_flag", 32'(load_use_hazard), 1);
      chk("lu_ready", 32'(in_ready), 0);
      step();
      eval(); peek();
      chk("lu_bubble", 32'(ex_valid), 0);
      chk("lu_count", bubble_count, 1);
      step();
      in_valid = 0; mem_rd = 3; mem_reg_write = 1; mem_result = 32'hABCD;
      eval(); peek();
      chk("lu_capture", 32'(ex_valid), 1);
      chk("lu_fwd", SrcB, 32'hABCD);
      step();

      // Stall holds a captured SUB
      idle();
      in_valid = 1; id_operation = 4'b0001; id_rd = 2; id_reg_write = 1;
      cycle();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         id_operation = 4'(i + 2); id_rd = 5'(i + 9);
         eval(); peek();
         chk("stall_op", 32'(Operation), 32'h1);
         chk("stall_ready", 32'(in_ready), 0);
         step();
      end
      flush = 1;
      cycle();
      flush = 0; stall = 0; in_valid = 0;
      eval(); peek();
      chk("flush_valid", 32'(ex_valid), 0);
      chk("flush_op", 32'(Operation), 32'h9);
      step();

      // Immediate / PC operand select
      idle();
      in_valid = 1; id_operation = 4'b0000; id_src_a_pc = 1; id_src_b_imm = 1;
      id_imm = 32'hFFFF_FFFC; id_pc = 32'h40; id_rs1 = 5; id_rs2 = 5;
      id_rs1_data = 1; id_rs2_data = 2;
      cycle();
      in_valid = 0; stall = 1; mem_rd = 5; mem_reg_write = 1; mem_result = 32'h1234;
      eval(); peek();
      chk("imm_srcb", SrcB, 32'hFFFF_FFFC);
      chk("pc_srca", SrcA, 32'h40);
      chk("imm_store", ex_store_data, 32'h1234);
      step();

      // Random traffic with a small register set to provoke hazards
      for (int n = 0; n < 2000; n++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         id_rs1       = 5'($urandom_range(0, 3));
         id_rs2       = 5'($urandom_range(0, 3));
         id_rd        = 5'($urandom_range(0, 3));
         id_use_rs1   = 1'($urandom_range(0, 1));
         id_use_rs2   = 1'($urandom_range(0, 1));
         id_src_a_pc  = ($urandom_range(0, 3) == 0);
         id_src_b_imm = ($urandom_range(0, 3) == 0);
         id_operation = 4'($urandom_range(0, 15));
         id_reg_write = 1'($urandom_range(0, 1));
         id_mem_read  = 1'($urandom_range(0, 1));
         id_mem_write = 1'($urandom_range(0, 1));
         id_rs1_data  = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
         stall        = ($urandom_range(0, 7) == 0);
         flush        = ($urandom_range(0, 9) == 0);
         mem_rd       = 5'($urandom_range(0, 3));
         mem_reg_write = 1'($urandom_range(0, 1));
         mem_result   = $urandom;
         wb_rd        = 5'($urandom_range(0, 3));
         wb_reg_write = 1'($urandom_range(0, 1));
         wb_result    = $urandom;
         reset        = ($urandom_range(0, 199) == 0);
         if (reset) begin
            m_ex = bubble();
            m_bc = 0;
         end
         cycle();
      end
      reset = 0;
      idle();
      cycle();
      peek();
      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

- Registered ID/EX boundary directly upstream of the `alu` block.
- Captures decoded instruction fields from decode under a valid/ready handshake.
- Resolves RAW hazards by forwarding from MEM and WB.
- Detects load-use hazards and inserts bubbles.
- Drives `SrcA`, `SrcB` and `Operation` straight into the ALU.
- Carries the EX-stage control bits onward to the EX/MEM register.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR`, 5, register index width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `in_valid` / `in_ready`  in / out  1  decode handshake; a transfer occurs when both are high at a posedge
- `id_rs1_data`, `id_rs2_data`, `id_imm`, `id_pc`  in  DATA_WIDTH  decoded operands
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR  register indices
- `id_use_rs1`, `id_use_rs2`  in  1  instruction reads rs1 / rs2
- `id_src_a_pc`  in  1  SrcA = PC instead of rs1
- `id_src_b_imm`  in  1  SrcB = imm instead of rs2
- `id_operation`  in  OPCODE_LENGTH  ALU code
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control bits
- `stall`  in  1  downstream hold
- `flush`  in  1  kill the EX-stage instruction (taken branch)
- `mem_rd`  in  REG_ADDR  MEM-stage destination register
- `mem_reg_write`  in  1  MEM-stage write enable
- `mem_result`  in  DATA_WIDTH  MEM-stage result
- `wb_rd`  in  REG_ADDR  WB-stage destination register
- `wb_reg_write`  in  1  WB-stage write enable
- `wb_result`  in  DATA_WIDTH  WB-stage result
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU code
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  EX-stage control
- `ex_rd`  out  REG_ADDR  EX-stage destination register
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2, used by stores
- `load_use_hazard`  out  1  combinational hazard flag
- `bubble_count`  out  32  saturating count of inserted bubbles

## Operation
- **Forwarding:** each of rs1/rs2 is taken from MEM when `mem_reg_write` is set, `mem_rd` is nonzero and equals the register index. Otherwise it is taken from WB under the same rule, otherwise from the captured register data. MEM has priority over WB; x0 is never forwarded.
- **Operand muxing:**
  - `SrcA` = `id_src_a_pc` ? captured PC : forwarded rs1.
  - `SrcB` = `id_src_b_imm` ? captured imm : forwarded rs2.
  - `ex_store_data` is always forwarded rs2.
- **Load-use hazard:** `load_use_hazard` is high when all of these hold:
  - `in_valid`, `ex_valid` and `ex_mem_read` are high and `ex_rd` is nonzero;
  - either (`id_use_rs1` and `id_rs1`==`ex_rd`) or (`id_use_rs2` and `id_rs2`==`ex_rd`).
- **`in_ready`** = !`stall` && !`load_use_hazard` (flush does not drop ready).
- **Register update at posedge, priority flush > stall > load-use > capture:**
  - flush: load a bubble.
  - stall: hold all fields.
  - load-use: load a bubble; decode holds its instruction.
  - `in_valid`: capture the decode fields, `ex_valid`=1.
  - otherwise: load a bubble.
- **Bubble:** `ex_valid`=0, `Operation`=4'b1001 (ALU no-op, result 0), all control bits 0, `ex_rd`=0, data fields 0.
- **`bubble_count`:** increments on each load-use bubble; saturates at 32'hFFFF_FFFF.

## Timing
- Reset (asynchronous, immediate): register holds a bubble, `bubble_count`=0.
  - Resulting outputs: `SrcA`=`SrcB`=0, `Operation`=4'b1001, `ex_valid`=0, `in_ready`=1 when `stall`=0.
  - Reset mid-operation discards the in-flight instruction.
- Latency: one cycle from transfer to `Operation` and the control outputs.
- `SrcA`/`SrcB`/`ex_store_data` combinationally follow `mem_result`/`wb_result` in the same cycle.
- A load-use stall costs exactly one bubble. The next cycle the load sits in MEM and the dependent instruction is captured with MEM→EX forwarding.
- Stall held N cycles: outputs constant for N cycles; forwarded values may change as MEM/WB change.
- Flush and stall in the same cycle: flush wins.
- Flush and load-use in the same cycle: bubble loaded, `bubble_count` not incremented.

## Structure
- Package `alu_pkg` holds:
  - ALU code constants: `ALU_ADD`=4'b0000, `ALU_SUB`=4'b0001, `ALU_NOP`=4'b1001, `ALU_LUI`=4'b1110, and the remaining codes.
  - enum `fwd_sel_t` {FWD_REG, FWD_MEM, FWD_WB}.
  - packed struct `idex_t` holding the registered fields.
- Sub-module `forward_unit`: combinational; takes rs indices and MEM/WB ports, returns two `fwd_sel_t`. Instantiated once.

## Test plan
- **Reset:** assert `reset` mid-capture → `ex_valid`=0 and `Operation`=4'b1001 immediately, before any clock edge.
- **Forward priority:** ADD with rs1=5, `mem_rd`=5 with `mem_result`=0x10, and `wb_rd`=5 with `wb_result`=0x20 → `SrcA`=0x10. Set `mem_reg_write`=0 → `SrcA`=0x20. Set rs1=0 → no forwarding.
- **Load-use:** LW x3 in EX, then ADD using rs2=3 presented by decode → `load_use_hazard`=1, `in_ready`=0. Next cycle `ex_valid`=0 and `bubble_count`=1; the following cycle ADD is captured.
- **Stall:** `stall` high for 3 cycles with SUB captured → `Operation`=4'b0001 held and `in_ready`=0 throughout.
- **Flush:** `flush`+`stall` in the same cycle → bubble next cycle.
- **Immediate/PC select:** `id_src_b_imm`=1 with imm=0xFFFFFFFC → `SrcB`=0xFFFFFFFC regardless of forwarding. `id_src_a_pc`=1 with PC=0x40 → `SrcA`=0x40.
